// File: rtl/vc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vc_arbiter
//  Purpose  : Weighted round-robin arbiter between two virtual-channel FIFOs.
//             Issues combinational pops and a registered mux selector /
//             valid pair aligned with the FIFOs' one-cycle read latency.
//  Revision : 1.0 - initial release
// ============================================================================
module vc_arbiter #(
    parameter int WEIGHT = 4,
    parameter int CW     = 3
) (
    input  logic clk,
    input  logic reset_L,
    input  logic empty0,
    input  logic empty1,
    input  logic stall,
    output logic pop0,
    output logic pop1,
    output logic selector,
    output logic valid_out
);

    localparam logic [CW-1:0] c_weight = CW'(WEIGHT);
    localparam logic [CW-1:0] c_one    = CW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic            r_last;
    logic            r_selector;
    logic            r_valid_out;
    logic            w_grant0;
    logic            w_grant1;

    // Grant decision: qualified by current empty flags, blocked by stall/reset.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!reset_L && !stall) begin
            case (r_state)
                IDLE: begin
                    if (r_last) begin
                        if (!empty0)      w_grant0 = 1'b1;
                        else if (!empty1) w_grant1 = 1'b1;
                    end else begin
                        if (!empty1)      w_grant1 = 1'b1;
                        else if (!empty0) w_grant0 = 1'b1;
                    end
                end
                SERVE0: begin
                    if (!empty0 && ((r_count < c_weight) || empty1)) w_grant0 = 1'b1;
                    else if (!empty1)                                  w_grant1 = 1'b1;
                end
                SERVE1: begin
                    if (!empty1 && ((r_count < c_weight) || empty0)) w_grant1 = 1'b1;
                    else if (!empty0)                                  w_grant0 = 1'b1;
                end
                default: begin
                    w_grant0 = 1'b0;
                    w_grant1 = 1'b0;
                end
            endcase
        end
    end

    // FSM, burst counter, last-served VC and registered mux outputs.
    always_ff @(posedge clk or posedge reset_L) begin
        if (reset_L) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_last      <= 1'b1;
            r_selector  <= 1'b0;
            r_valid_out <= 1'b0;
        end else if (stall) begin
            // Arbitration frozen; only the output valid drops.
            r_valid_out <= 1'b0;
        end else if (w_grant0) begin
            r_state     <= SERVE0;
            r_last      <= 1'b0;
            r_selector  <= 1'b0;
            r_valid_out <= 1'b1;
            if (r_state == SERVE0)
                r_count <= (r_count == c_weight) ? r_count : r_count + c_one;
            else
                r_count <= c_one;
        end else if (w_grant1) begin
            r_state     <= SERVE1;
            r_last      <= 1'b1;
            r_selector  <= 1'b1;
            r_valid_out <= 1'b1;
            if (r_state == SERVE1)
                r_count <= (r_count == c_weight) ? r_count : r_count + c_one;
            else
                r_count <= c_one;
        end else begin
            // Both VCs empty: fall back to IDLE, keep selector and last.
            r_state     <= IDLE;
            r_count     <= '0;
            r_valid_out <= 1'b0;
        end
    end

    assign pop0      = w_grant0;
    assign pop1      = w_grant1;
    assign selector  = r_selector;
    assign valid_out = r_valid_out;

endmodule
`default_nettype wire

// File: tb/tb_vc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vc_arbiter
//  Purpose  : Directed self-checking bench for vc_arbiter (WEIGHT = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vc_arbiter;

    logic clk;
    logic reset_L;
    logic empty0;
    logic empty1;
    logic stall;
    logic pop0;
    logic pop1;
    logic selector;
    logic valid_out;

    int   n_checks;
    int   n_fail;

    vc_arbiter #(.WEIGHT(4), .CW(3)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .empty0    (empty0),
        .empty1    (empty1),
        .stall     (stall),
        .pop0      (pop0),
        .pop1      (pop1),
        .selector  (selector),
        .valid_out (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, check all outputs mid-cycle, advance.
    task automatic vec(input string tag, input logic e0, input logic e1, input logic st,
                       input logic ep0, input logic ep1, input logic esel, input logic evld);
        empty0 = e0;
        empty1 = e1;
        stall  = st;
        @(negedge clk);
        chk({tag, ".pop0"},      pop0,      ep0);
        chk({tag, ".pop1"},      pop1,      ep1);
        chk({tag, ".selector"},  selector,  esel);
        chk({tag, ".valid_out"}, valid_out, evld);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_L = 1'b1;
        @(posedge clk);
        #1;
        reset_L = 1'b0;
    endtask

    initial begin
        logic [11:0] pat;
        n_checks = 0;
        n_fail   = 0;
        reset_L  = 1'b1;
        empty0   = 1'b0;
        empty1   = 1'b0;
        stall    = 1'b0;

        // Reset held with both VCs non-empty: nothing pops.
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst.pop0", pop0, 1'b0);
        chk("rst.pop1", pop1, 1'b0);
        chk("rst.selector", selector, 1'b0);
        chk("rst.valid_out", valid_out, 1'b0);
        @(posedge clk);
        #1;
        reset_L = 1'b0;

        // Both non-empty: bursts of 4, selector delayed one cycle.
        pat = 12'b0000_1111_0000;
        for (int i = 0; i < 12; i++) begin
            vec($sformatf("rr%0d", i), 1'b0, 1'b0, 1'b0,
                ~pat[i], pat[i], (i == 0) ? 1'b0 : pat[i-1], (i != 0));
        end

        // Only VC1 non-empty: no forced switch, selector stays 1.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            vec($sformatf("vc1only%0d", i), 1'b1, 1'b0, 1'b0,
                1'b0, 1'b1, (i != 0), (i != 0));
        end

        // Stall for 3 cycles after two VC0 grants; burst resumes with 2 more.
        do_reset();
        vec("stl0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vec("stl1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        vec("stl2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vec("stl3", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vec("stl4", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vec("stl5", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vec("stl6", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        vec("stl7", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        vec("stl8", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Single VC0 word, then idle; IDLE then prefers VC1 (last was VC0).
        do_reset();
        vec("one0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vec("one1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vec("one2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vec("one3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vec("one4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        vec("one5", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // VC0 drains mid-burst: switch to VC1 in the same cycle.
        do_reset();
        vec("drn0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vec("drn1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        vec("drn2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Asynchronous reset mid VC1 burst: pop drops at once, VC0 wins after.
        do_reset();
        vec("ar0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vec("ar1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        #2;
        chk("ar.pop1_before", pop1, 1'b1);
        reset_L = 1'b1;
        #1;
        chk("ar.pop1_async", pop1, 1'b0);
        chk("ar.sel_async", selector, 1'b0);
        chk("ar.vld_async", valid_out, 1'b0);
        empty0 = 1'b0;
        empty1 = 1'b0;
        @(posedge clk);
        #1;
        reset_L = 1'b0;
        vec("ar2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the bench never runs away.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
